// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and an iterative restoring divider.
// Non-divide ops (and divide by zero) complete on the accept edge; divides take WIDTH cycles.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             DivByZero
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [3:0] OP_DIV = 4'b0011;
  // The accept edge already produces the quotient MSB, so the counter starts one bit lower.
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH - 2);

  typedef enum logic {IDLE, DIV} state_t;

  // Returns {carry, result} for every single-cycle opcode.
  function automatic logic [WIDTH:0] alu_op(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [3:0]       sel);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     r;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    r = '0;
    case (sel)
      4'b0000: r = {1'b0, a} + {1'b0, b};
      4'b0001: r = {a < b, a - b};
      4'b0010: r = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
      4'b0011: r = {1'b0, {WIDTH{1'b1}}};
      4'b0100: r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      4'b0101: r = {a[0], 1'b0, a[WIDTH-1:1]};
      4'b0110: r = {1'b0, a[WIDTH-2:0], a[WIDTH-1]};
      4'b0111: r = {1'b0, a[0], a[WIDTH-1:1]};
      4'b1000: r = {1'b0, a & b};
      4'b1001: r = {1'b0, a | b};
      4'b1010: r = {1'b0, a ^ b};
      4'b1011: r = {1'b0, ~(a | b)};
      4'b1100: r = {1'b0, ~(a & b)};
      4'b1101: r = {1'b0, ~(a ^ b)};
      4'b1110: r = {{WIDTH{1'b0}}, a > b};
      4'b1111: r = {{WIDTH{1'b0}}, a == b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // One restoring step: q carries the unconsumed dividend bits in and the quotient bits out.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0] trial;
    trial = {rem, q[WIDTH-1]};
    if (trial >= {1'b0, d})
      return {trial[WIDTH-1:0] - d, q[WIDTH-2:0], 1'b1};
    return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt_p1;
  logic [WIDTH-1:0]   rem_p1, quo_p1, dvs_p1;
  logic               accept, out_free, div_start, div_done, div_iter;
  logic               load_en, load_c, load_dz;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH:0]     alu_res;
  logic [2*WIDTH-1:0] step_first, step_iter;

  assign out_free   = !out_valid || out_ready;
  assign in_ready   = !reset && (state == IDLE) && out_free;
  assign accept     = in_valid && in_ready;
  assign alu_res    = alu_op(A, B, ALU_Sel);
  assign step_first = div_step('0, A, B);
  assign step_iter  = div_step(rem_p1, quo_p1, dvs_p1);
  assign div_start  = accept && (ALU_Sel == OP_DIV) && (B != '0);
  assign div_iter   = (state == DIV) && (cnt_p1 != '0);
  // The last step is held combinationally until the output register can take it.
  assign div_done   = (state == DIV) && (cnt_p1 == '0) && out_free;

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    load_val  = '0;
    load_c    = 1'b0;
    load_dz   = 1'b0;
    case (state)
      IDLE: begin
        if (div_start) begin
          state_nxt = DIV;
        end else if (accept) begin
          load_en  = 1'b1;
          load_val = alu_res[WIDTH-1:0];
          load_c   = alu_res[WIDTH];
          load_dz  = (ALU_Sel == OP_DIV);
        end
      end
      DIV: begin
        if (div_done) begin
          state_nxt = IDLE;
          load_en   = 1'b1;
          load_val  = step_iter[WIDTH-1:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p1: divider working registers
  always_ff @(posedge clk) begin
    if (div_start) begin
      {rem_p1, quo_p1} <= step_first;
      dvs_p1           <= B;
    end else if (div_iter) begin
      {rem_p1, quo_p1} <= step_iter;
    end
  end

  // Output stage: control state plus the result register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt_p1    <= '0;
      out_valid <= 1'b0;
      ALU_Out   <= '0;
      CarryOut  <= 1'b0;
      Zero      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (div_start)
        cnt_p1 <= CNT_START;
      else if (div_iter)
        cnt_p1 <= cnt_p1 - CNT_W'(1);
      if (load_en) begin
        out_valid <= 1'b1;
        ALU_Out   <= load_val;
        CarryOut  <= load_c;
        Zero      <= (load_val == '0);
        DivByZero <= load_dz;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: WIDTH=8 instance for the main plan, WIDTH=16 for the wide divide/multiply.
module tb_alu_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, CarryOut, Zero, DivByZero;
  logic [7:0] A, B, ALU_Out;
  logic [3:0] ALU_Sel;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_carry, w_zero, w_dbz;
  logic [15:0] w_a, w_b, w_out;
  logic [3:0]  w_sel;

  int n_chk = 0;
  int n_fail = 0;
  int stalls = 0;
  int busy_bad = 0;
  int cyc;
  logic [10:0] sb8[$];
  logic [18:0] sb16[$];
  logic [10:0] e8;
  logic [18:0] e16;

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Zero(Zero), .DivByZero(DivByZero)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .A(w_a), .B(w_b), .ALU_Sel(w_sel), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .ALU_Out(w_out), .CarryOut(w_carry), .Zero(w_zero), .DivByZero(w_dbz)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Monitors: any handshake at the coming edge pops one expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb8.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected8: got %0h with no expected result", {ALU_Out, CarryOut, Zero, DivByZero});
      end else begin
        e8 = sb8.pop_front();
        check("result8 {out,c,z,dz}", {ALU_Out, CarryOut, Zero, DivByZero}, e8);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && w_out_valid && w_out_ready) begin
      if (sb16.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected16: got %0h with no expected result", {w_out, w_carry, w_zero, w_dbz});
      end else begin
        e16 = sb16.pop_front();
        check("result16 {out,c,z,dz}", {w_out, w_carry, w_zero, w_dbz}, e16);
      end
    end
  end

  task automatic send8(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                       input bit push, input logic [10:0] exp);
    int guard;
    ALU_Sel = sel; A = a; B = b; in_valid = 1'b1; guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      stalls++; guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send8_timeout: in_ready got 0, expected 1 within 100 cycles");
    end else if (push) begin
      sb8.push_back(exp);
    end
    sync();
    in_valid = 1'b0;
  endtask

  task automatic send16(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                        input logic [18:0] exp);
    int guard;
    w_sel = sel; w_a = a; w_b = b; w_in_valid = 1'b1; guard = 0;
    @(negedge clk);
    while (!w_in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!w_in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send16_timeout: in_ready got 0, expected 1 within 100 cycles");
    end else begin
      sb16.push_back(exp);
    end
    sync();
    w_in_valid = 1'b0;
  endtask

  // Counts cycles after accept until out_valid shows; in_ready must stay low meanwhile.
  task automatic wait8(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid && in_ready) busy_bad++;
    end while (!out_valid && n < 100);
  endtask

  task automatic wait16(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!w_out_valid && w_in_ready) busy_bad++;
    end while (!w_out_valid && n < 100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALU_Sel = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_sel = '0; w_out_ready = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {ALU_Out, CarryOut, Zero, DivByZero}, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid16", w_out_valid, 0);
    sync();
    reset = 1'b0; out_ready = 1'b1; w_out_ready = 1'b1;

    send8(4'b0000, 8'hF0, 8'h20, 1, {8'h10, 3'b100});
    @(negedge clk);
    check("add_latency_valid", out_valid, 1);
    sync();

    stalls = 0;
    send8(4'b0001, 8'h05, 8'h07, 1, {8'hFE, 3'b100});
    send8(4'b1100, 8'hFF, 8'h0F, 1, {8'hF0, 3'b000});
    send8(4'b0110, 8'h81, 8'h00, 1, {8'h03, 3'b000});
    send8(4'b1111, 8'h03, 8'h03, 1, {8'h01, 3'b000});
    check("stream_stalls", stalls, 0);

    send8(4'b0000, 8'hFF, 8'h01, 1, {8'h00, 3'b110});
    send8(4'b0100, 8'h80, 8'h00, 1, {8'h00, 3'b110});
    send8(4'b0101, 8'h01, 8'h00, 1, {8'h00, 3'b110});
    send8(4'b0111, 8'h01, 8'h00, 1, {8'h80, 3'b000});
    send8(4'b1000, 8'hF0, 8'h3C, 1, {8'h30, 3'b000});
    send8(4'b1001, 8'hF0, 8'h0F, 1, {8'hFF, 3'b000});
    send8(4'b1010, 8'hAA, 8'hFF, 1, {8'h55, 3'b000});
    send8(4'b1011, 8'h00, 8'h00, 1, {8'hFF, 3'b000});
    send8(4'b1101, 8'hAA, 8'h0F, 1, {8'h5A, 3'b000});
    send8(4'b1110, 8'h05, 8'h03, 1, {8'h01, 3'b000});
    send8(4'b1110, 8'h03, 8'h05, 1, {8'h00, 3'b010});
    send8(4'b0010, 8'h0F, 8'h11, 1, {8'hFF, 3'b000});
    send8(4'b0001, 8'h07, 8'h05, 1, {8'h02, 3'b000});

    busy_bad = 0;
    send8(4'b0011, 8'd200, 8'd7, 1, {8'd28, 3'b000});
    wait8(cyc);
    check("div_latency", cyc, 8);
    sync();
    send8(4'b0011, 8'd9, 8'd0, 1, {8'hFF, 3'b001});
    wait8(cyc);
    check("div0_latency", cyc, 1);
    sync();
    send8(4'b0011, 8'd7, 8'd200, 1, {8'h00, 3'b010});
    wait8(cyc);
    check("div_small_latency", cyc, 8);
    check("div_in_ready_low", busy_bad, 0);
    sync();

    out_ready = 1'b0;
    send8(4'b0010, 8'h10, 8'h10, 1, {8'h00, 3'b110});
    ALU_Sel = 4'b0000; A = 8'h01; B = 8'h01; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_hold", {ALU_Out, CarryOut, Zero, DivByZero}, {8'h00, 3'b110});
      check("bp_in_ready", in_ready, 0);
    end
    sync();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    sync();

    send8(4'b0011, 8'd200, 8'd7, 0, '0);
    repeat (3) sync();
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_ready_in_reset", in_ready, 0);
    sync();
    reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_outputs", {ALU_Out, CarryOut, Zero, DivByZero}, 0);
    check("abort_in_ready", in_ready, 1);
    sync();
    send8(4'b0000, 8'h01, 8'h01, 1, {8'h02, 3'b000});
    @(negedge clk);
    check("post_reset_add_valid", out_valid, 1);
    sync();

    busy_bad = 0;
    send16(4'b0011, 16'hFFFF, 16'h0003, {16'h5555, 3'b000});
    wait16(cyc);
    check("div16_latency", cyc, 16);
    check("div16_in_ready_low", busy_bad, 0);
    sync();
    send16(4'b0010, 16'h0100, 16'h0100, {16'h0000, 3'b110});
    @(negedge clk);
    check("mul16_valid", w_out_valid, 1);
    sync();
    send16(4'b0010, 16'h00FF, 16'h00FF, {16'hFE01, 3'b000});
    @(negedge clk);
    sync();

    repeat (3) sync();
    check("sb8_drained", sb8.size(), 0);
    check("sb16_drained", sb16.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
